// File: rtl/chiplet_types_pkg.sv
// Shared types and constants for the switch ingress slice.
// Holds the VC index type, perf-counter width and the VC index width helper.
// No logic; imported by switch_vc_ingress and vc_fifo.
package chiplet_types_pkg;

    // Width of the optional per-VC and stall performance counters.
    localparam int PERF_CNT_W = 16;

    // VC index for the default four-VC port configuration.
    localparam int VC_IDX_W = 2;
    typedef logic [VC_IDX_W-1:0] vc_idx_t;

    // VC index width: max(1, clog2(n)), so a two-VC port still gets one bit.
    function automatic int vc_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO with an occupancy count and a registered-pointer head view.
// Latency: a push is visible at head_flit / count one cycle after the write edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports: clk, n_rst (async active-low), flush (sync clear), push/push_flit,
//        pop, head_flit (oldest entry), count (entries held, 0..DEPTH).
module vc_fifo
    import chiplet_types_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int FLIT_W = 64,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_flit,
    input  logic              pop,
    output logic [FLIT_W-1:0] head_flit,
    output logic [CNT_W-1:0]  count
);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Storage is deliberately not reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_flit;
        end
    end

    assign head_flit = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Explicit wrap so DEPTH need not be a power of two.
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_vc_ingress.sv
// Per-port VC ingress buffer: NUM_VCS FIFOs, round-robin drain into one output register.
// Latency: 2 cycles from in_valid to out_valid; no bypass path. 1 flit/cycle sustained.
// Backpressure: out_valid/out_ready on the output; credit_return pulses upstream per freed slot.
//
// Ports: clk, n_rst (async active-low), in_valid/in_flit/in_vc, flush,
//        buffer_available, credit_return, out_valid/out_ready/out_flit/out_vc,
//        overflow_err (sticky per VC), bad_vc_err (sticky).
// Optional: define SWITCH_VC_INGRESS_PERF_EN to add vc_flit_cnt and stall_cnt.
module switch_vc_ingress
    import chiplet_types_pkg::*;
#(
    parameter  int NUM_VCS = 4,
    parameter  int DEPTH   = 8,
    parameter  int FLIT_W  = 64,
    localparam int VC_W    = vc_width(NUM_VCS)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    input  logic [FLIT_W-1:0]  in_flit,
    input  logic [VC_W-1:0]    in_vc,
    input  logic               flush,
    output logic [NUM_VCS-1:0] buffer_available,
    output logic [NUM_VCS-1:0] credit_return,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLIT_W-1:0]  out_flit,
    output logic [VC_W-1:0]    out_vc,
    output logic [NUM_VCS-1:0] overflow_err,
    output logic               bad_vc_err
`ifdef SWITCH_VC_INGRESS_PERF_EN
    ,
    output logic [NUM_VCS-1:0][PERF_CNT_W-1:0] vc_flit_cnt,
    output logic [PERF_CNT_W-1:0]              stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]   count [NUM_VCS];
    logic [FLIT_W-1:0]  head  [NUM_VCS];
    logic [NUM_VCS-1:0] vc_sel;
    logic [NUM_VCS-1:0] vc_full;
    logic [NUM_VCS-1:0] nonempty;
    logic [NUM_VCS-1:0] push;
    logic [NUM_VCS-1:0] pop;
    logic               bad_vc;
    logic               load;
    logic               grant_found;
    logic [VC_W-1:0]    grant;
    logic [VC_W-1:0]    rr_ptr;

    // Decoding in_vc against each VC keeps out-of-range indices away from
    // any array lookup: an index matching no VC is exactly the bad case.
    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign vc_sel[v]   = in_valid && (in_vc == VC_W'(v));
        assign vc_full[v]  = (count[v] == CNT_W'(DEPTH));
        assign nonempty[v] = (count[v] != '0);
        // Fullness is taken from the registered count, so a same-cycle pop
        // does not rescue a push to a full VC.
        assign push[v]     = vc_sel[v] && !vc_full[v] && !flush;
        assign pop[v]      = load && (grant == VC_W'(v));

        vc_fifo #(
            .DEPTH  (DEPTH),
            .FLIT_W (FLIT_W)
        ) u_fifo (
            .clk       (clk),
            .n_rst     (n_rst),
            .flush     (flush),
            .push      (push[v]),
            .push_flit (in_flit),
            .pop       (pop[v]),
            .head_flit (head[v]),
            .count     (count[v])
        );
    end

    assign buffer_available = ~vc_full;
    assign bad_vc           = in_valid && (vc_sel == '0);

    // Round-robin: first non-empty VC at or above rr_ptr, wrapping modulo NUM_VCS.
    always_comb begin
        logic [VC_W:0] idx;
        idx         = '0;
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_VCS; i++) begin
            idx = {1'b0, rr_ptr} + (VC_W + 1)'(i);
            if (idx >= (VC_W + 1)'(NUM_VCS)) begin
                idx = idx - (VC_W + 1)'(NUM_VCS);
            end
            if (!grant_found && nonempty[idx[VC_W-1:0]]) begin
                grant_found = 1'b1;
                grant       = idx[VC_W-1:0];
            end
        end
    end

    assign load = (!out_valid || out_ready) && grant_found && !flush;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr        <= '0;
            out_valid     <= 1'b0;
            out_flit      <= '0;
            out_vc        <= '0;
            credit_return <= '0;
            overflow_err  <= '0;
            bad_vc_err    <= 1'b0;
        end else begin
            // Error flags are sticky and survive flush.
            overflow_err <= overflow_err | (vc_sel & vc_full);
            if (bad_vc) begin
                bad_vc_err <= 1'b1;
            end

            if (flush) begin
                rr_ptr        <= '0;
                out_valid     <= 1'b0;
                credit_return <= '0;
            end else begin
                // Credit lands in the same cycle the freed slot shows in count.
                credit_return <= pop;
                if (load) begin
                    out_valid <= 1'b1;
                    out_flit  <= head[grant];
                    out_vc    <= grant;
                    rr_ptr    <= (grant == VC_W'(NUM_VCS - 1)) ? '0 : grant + 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef SWITCH_VC_INGRESS_PERF_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vc_flit_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (push[v] && (vc_flit_cnt[v] != '1)) begin
                    vc_flit_cnt[v] <= vc_flit_cnt[v] + PERF_CNT_W'(1);
                end
            end
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule
